// File: rtl/lector_cadena.sv
// Sequential string reader: walks a synchronous-read memory from address 0 and streams
// each byte on a valid/ready port until TERM or LAST. Define LECTOR_MAYUS_EN for 'a'-'z' uppercasing.
module lector_cadena #(
  parameter int unsigned       ADDR_W = 5,
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       LAST   = 31,
  parameter logic [DATA_W-1:0] TERM   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] dir,
  input  logic [DATA_W-1:0] dataMem,
  output logic [DATA_W-1:0] dataOut,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   cnt
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_SEND,
    S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_dir, w_dir_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [DATA_W-1:0]   w_conv;
  logic                r_valid, w_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic [ADDR_W:0]     r_cnt, w_cnt_nxt;

`ifdef LECTOR_MAYUS_EN
  // Lowercase ASCII maps to uppercase; TERM detection still uses the raw byte.
  always_comb begin
    w_conv = dataMem;
    if ((dataMem >= DATA_W'(8'h61)) && (dataMem <= DATA_W'(8'h7A))) begin
      w_conv = dataMem - DATA_W'(8'h20);
    end
  end
`else
  assign w_conv = dataMem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dir   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and next-register values; busy/done are derived from the next state so they stay registered.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_dir_nxt   = '0;
        w_valid_nxt = 1'b0;
        if (start) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_READ;
        end
      end
      S_READ: w_state_nxt = S_CAPT;
      S_CAPT: begin
        if (dataMem == TERM) begin
          w_state_nxt = S_DONE;
        end else begin
          w_data_nxt  = w_conv;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (ready) begin
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = r_cnt + (ADDR_W+1)'(1);
          if (r_dir == LAST_A) begin
            w_state_nxt = S_DONE;
          end else begin
            w_dir_nxt   = r_dir + ADDR_W'(1);
            w_state_nxt = S_READ;
          end
        end
      end
      S_DONE: begin
        w_dir_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign dir     = r_dir;
  assign dataOut = r_data;
  assign valid   = r_valid;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cnt     = r_cnt;

endmodule

// File: tb/tb_lector_cadena.sv
// Bench for lector_cadena: synchronous-read memory model, stream monitor and a queue-based reference.
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
module tb_lector_cadena;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] dir;
  logic [7:0] dataMem;
  logic [7:0] dataOut;
  logic       valid;
  logic       ready = 1'b1;
  logic       busy;
  logic       done;
  logic [5:0] cnt;

  lector_cadena dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .dataMem(dataMem),
    .dataOut(dataOut), .valid(valid), .ready(ready), .busy(busy), .done(done), .cnt(cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32];
  always @(posedge clk) dataMem <= mem[dir];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q [$];
  logic [4:0] dir_q [$];
  logic [7:0] exp_q [$];
  int         done_cnt = 0;
  int         stab_err = 0;
  bit         pend = 1'b0;
  logic [7:0] pend_data = 8'h00;

  int cycles, first_valid, timeout;
  logic busy_at_start;

  // Stream monitor: records accepted bytes and flags a held byte that changes or vanishes.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (valid) begin
        if (pend && dataOut !== pend_data) stab_err++;
        if (ready) begin
          rx_q.push_back(dataOut);
          dir_q.push_back(dir);
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          pend_data = dataOut;
        end
      end else begin
        if (pend) stab_err++;
        pend = 1'b0;
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [7:0] to_out(input logic [7:0] b);
`ifdef LECTOR_MAYUS_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  // Reference: bytes from address 0 up to (not including) the first zero, or all 32.
  task automatic build_expected();
    exp_q.delete();
    for (int a = 0; a < 32; a++) begin
      if (mem[a] == 8'h00) break;
      exp_q.push_back(to_out(mem[a]));
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < 32; a++) mem[a] = 8'($urandom_range(0, 255));
  endtask

  // Runs one scan; start is sampled at the first edge, optionally re-pulsed at cycle pulse_cyc.
  task automatic run_scan(input bit rand_rdy, input int pulse_cyc);
    rx_q.delete(); dir_q.delete(); done_cnt = 0; stab_err = 0; timeout = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_at_start = busy;
    cycles = 0; first_valid = -1;
    forever begin
      if (valid && first_valid < 0) first_valid = cycles;
      if (done || cycles >= 1000) break;
      if (rand_rdy) ready = 1'($urandom_range(0, 1));
      start = (cycles == pulse_cyc);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    if (cycles >= 1000) timeout = 1;
    ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_checks++; if (dir !== 5'd0)     begin n_fail++; $display("FAIL reset_dir got %0d want 0", dir); end
    n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL reset_dataOut got %h want 00", dataOut); end
    n_checks++; if (valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (cnt !== 6'd0)     begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt); end
  endtask

  task automatic test_basic();
    fill_random();
    mem[0] = 8'h41; mem[1] = 8'h6E; mem[2] = 8'h61; mem[3] = 8'h00;
    build_expected();
    run_scan(1'b0, -1);
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_len got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (cnt !== 6'd3)     begin n_fail++; $display("FAIL basic_cnt got %0d want 3", cnt); end
    n_checks++; if (done_cnt != 1)    begin n_fail++; $display("FAIL basic_done got %0d want 1", done_cnt); end
    n_checks++; if (cycles != 11)     begin n_fail++; $display("FAIL basic_latency got %0d want 11", cycles); end
    n_checks++; if (first_valid != 2) begin n_fail++; $display("FAIL basic_first_valid got %0d want 2", first_valid); end
    n_checks++; if (busy_at_start !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got %b want 1", busy_at_start); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL basic_busy_fall got %b want 0", busy); end
  endtask

  task automatic test_empty();
    fill_random();
    mem[0] = 8'h00;
    run_scan(1'b0, -1);
    n_checks++; if (first_valid != -1)  begin n_fail++; $display("FAIL empty_valid got %0d want -1", first_valid); end
    n_checks++; if (rx_q.size() != 0)   begin n_fail++; $display("FAIL empty_len got %0d want 0", rx_q.size()); end
    n_checks++; if (cycles != 2)        begin n_fail++; $display("FAIL empty_done_latency got %0d want 2", cycles); end
    n_checks++; if (done_cnt != 1)      begin n_fail++; $display("FAIL empty_done got %0d want 1", done_cnt); end
    n_checks++; if (cnt !== 6'd0)       begin n_fail++; $display("FAIL empty_cnt got %0d want 0", cnt); end
  endtask

  task automatic test_full();
    for (int a = 0; a < 32; a++) mem[a] = 8'h31;
    run_scan(1'b0, -1);
    n_checks++; if (rx_q.size() != 32) begin n_fail++; $display("FAIL full_len got %0d want 32", rx_q.size()); end
    for (int i = 0; i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== 8'h31 || dir_q[i] !== 5'(i)) begin
        n_fail++; $display("FAIL full_byte%0d got %h@%0d want 31@%0d", i, rx_q[i], dir_q[i], i);
      end
    end
    n_checks++; if (cnt !== 6'd32)  begin n_fail++; $display("FAIL full_cnt got %0d want 32", cnt); end
    n_checks++; if (cycles != 96)   begin n_fail++; $display("FAIL full_latency got %0d want 96", cycles); end
    n_checks++; if (dir !== 5'd0)   begin n_fail++; $display("FAIL full_dir_return got %0d want 0", dir); end
    n_checks++; if (done_cnt != 1)  begin n_fail++; $display("FAIL full_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int len;
      len = $urandom_range(0, 32);
      fill_random();
      for (int a = 0; a < 32; a++) begin
        if (a < len) mem[a] = 8'($urandom_range(1, 255));
        else if (a == len) mem[a] = 8'h00;
      end
      build_expected();
      run_scan(1'b1, -1);
      n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len got %0d want %0d", it, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d got %h want %h", it, i, rx_q[i], exp_q[i]); end
      end
      n_checks++; if (cnt !== 6'(exp_q.size())) begin n_fail++; $display("FAIL rand%0d_cnt got %0d want %0d", it, cnt, exp_q.size()); end
      n_checks++; if (done_cnt != 1 || timeout != 0) begin n_fail++; $display("FAIL rand%0d_done got %0d/%0d want 1/0", it, done_cnt, timeout); end
      n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL rand%0d_stable got %0d want 0", it, stab_err); end
    end
  endtask

  task automatic test_backpressure();
    int k;
    fill_random();
    mem[0] = 8'h32; mem[1] = 8'h31; mem[2] = 8'h35; mem[3] = 8'h36; mem[4] = 8'h00;
    build_expected();
    rx_q.delete(); dir_q.delete(); done_cnt = 0; stab_err = 0;
    start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(valid && rx_q.size() == 1) && k < 50) begin @(posedge clk); #1; k++; end
    n_checks++; if (k >= 50) begin n_fail++; $display("FAIL bp_wait_second got timeout want byte"); end
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++; if (valid !== 1'b1 || dataOut !== 8'h31) begin
        n_fail++; $display("FAIL bp_hold%0d got %b/%h want 1/31", c, valid, dataOut);
      end
    end
    ready = 1'b1;
    k = 0;
    while (!done && k < 50) begin @(posedge clk); #1; k++; end
    n_checks++; if (k >= 50) begin n_fail++; $display("FAIL bp_wait_done got timeout want done"); end
    @(posedge clk); #1;
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_len got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (cnt !== 6'd4)  begin n_fail++; $display("FAIL bp_cnt got %0d want 4", cnt); end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable got %0d want 0", stab_err); end
  endtask

  task automatic test_start_ignored();
    fill_random();
    mem[0] = 8'h41; mem[1] = 8'h6E; mem[2] = 8'h61; mem[3] = 8'h00;
    build_expected();
    run_scan(1'b0, 4);
    n_checks++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL restart_len got %0d want 3", rx_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (cycles != 11 || cnt !== 6'd3) begin n_fail++; $display("FAIL restart_timing got %0d/%0d want 11/3", cycles, cnt); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int k;
    fill_random();
    mem[0] = 8'h41; mem[1] = 8'h6E; mem[2] = 8'h61; mem[3] = 8'h00;
    rx_q.delete();
    start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(valid && rx_q.size() == 1) && k < 50) begin @(posedge clk); #1; k++; end
    ready = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags got v%b b%b d%b want 000", valid, busy, done);
    end
    n_checks++; if (dir !== 5'd0 || dataOut !== 8'h00 || cnt !== 6'd0) begin
      n_fail++; $display("FAIL rstmid_regs got %0d/%h/%0d want 0/00/0", dir, dataOut, cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    build_expected();
    run_scan(1'b0, -1);
    n_checks++; if (rx_q.size() != 3 || dir_q.size() == 0 || dir_q[0] !== 5'd0) begin
      n_fail++; $display("FAIL rstmid_restart_len got %0d want 3 from addr 0", rx_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    fill_random();
    mem[0] = 8'h00;
    start = 1'b1;
    k = 0;
    while (!done && k < 20) begin @(posedge clk); #1; k++; end
    n_checks++; if (k >= 20) begin n_fail++; $display("FAIL b2b_wait got timeout want done"); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_relaunch got %b want 1", busy); end
    k = 0;
    while (!done && k < 20) begin @(posedge clk); #1; k++; end
    n_checks++; if (k >= 20) begin n_fail++; $display("FAIL b2b_wait2 got timeout want done"); end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int a = 0; a < 32; a++) mem[a] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_empty();
    test_full();
    test_random();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lector_cadena.md
# lector_cadena

Sequential string reader that sits directly downstream of the 32×8 synchronous-read memory. On `start` it walks memory addresses from 0, fetches one byte per address through the memory's registered read port, and emits each byte on a valid/ready byte stream. It stops at a terminator byte or at the last address. It is the stage that turns the stored ASCII text, a name or digit string, into a character stream for display or serial output.

## Interface
Parameters:
- `ADDR_W`, 5: memory address width.
- `DATA_W`, 8: byte width.
- `LAST`, 31: last address scanned; the scan ends after emitting this address.
- `TERM`, 8'h00: terminator byte; it ends the scan and is not emitted.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: begin a scan; sampled only in IDLE.
- `dir`, output, ADDR_W: read address driven to the memory's synchronous read port.
- `dataMem`, input, DATA_W: memory synchronous read data; valid one clock after `dir` is sampled.
- `dataOut`, output, DATA_W: emitted byte, registered.
- `valid`, output, 1: `dataOut` holds a byte.
- `ready`, input, 1: consumer accepts `dataOut` on a clock edge where `valid & ready`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when a scan ends.
- `cnt`, output, ADDR_W+1: number of bytes emitted in the current or last scan.

## Operation
States: IDLE, READ, CAPT, SEND, DONE.
- **IDLE:** `dir`=0, `valid`=0.
  - `start`=1: `cnt`←0, go to READ.
- **READ:** `dir` is held stable; the memory samples it at this edge.
  - Always go to CAPT.
- **CAPT:** `dataMem` now corresponds to `dir`.
  - `dataMem`==TERM: go to DONE, nothing emitted.
  - Otherwise: `dataOut`←`dataMem` (case conversion applies when compiled in), `valid`←1, go to SEND.
- **SEND:** `valid`=1, `dataOut` held stable while `ready`=0.
  - On `ready`=1: `valid`←0, `cnt`←`cnt`+1.
  - If `dir`==LAST, go to DONE.
  - Otherwise `dir`←`dir`+1, go to READ.
- **DONE:** `done`=1 for exactly this cycle, `dir`←0, then go to IDLE.

Rules:
- `start` while `busy` is ignored. A `start` held high through DONE launches a new scan from IDLE on the next cycle.
- The address never wraps. `dir`==LAST ends the scan, so `dir` never exceeds LAST.
- A TERM byte at address 0 gives an empty scan: `done` pulses, `cnt`=0, `valid` never rises.
- A full scan with no TERM byte emits LAST+1 bytes; `cnt`=32 with the defaults.
- The block never writes the memory. Concurrent writes by the upstream writer to the address being read return whatever byte the memory's registered port delivers.
- Reset asserted mid-scan forces IDLE immediately and clears all outputs. A byte pending in SEND is discarded.

## Timing
- Reset values: `dir`=0, `dataOut`=0, `valid`=0, `busy`=0, `done`=0, `cnt`=0, state IDLE.
- Start latency: if `start` is sampled at edge E, `busy` rises after E, and `valid` with the first byte rises after edge E+2.
- Throughput with `ready` held high: one byte per 3 cycles (READ, CAPT, SEND).
- Each low cycle of `ready` in SEND adds one cycle.
- End latency: `done` is high the cycle after the TERM-detect edge or the final accept edge. `busy` falls one cycle after `done`.
- All outputs are registered; there is no combinational path from `ready` or `dataMem` to any output.

## Configuration
- `LECTOR_MAYUS_EN`:
  - Defined: bytes in 8'h61–8'h7A ('a'–'z') are emitted minus 8'h20 (uppercase). All other bytes pass unchanged. The comparison against TERM uses the raw `dataMem` value.
  - Undefined: bytes pass unchanged, and no conversion logic is synthesized.

## Test plan
- **Basic string:** preload addresses 0–3 = "Ana",8'h00; pulse `start`; `ready`=1 → `dataOut` sequence 8'h41,8'h6E,8'h61. Bytes are 3 cycles apart, `done` pulses once, `cnt`=3. With `LECTOR_MAYUS_EN` defined: 8'h41,8'h4E,8'h41.
- **Empty string:** address 0 = 8'h00; pulse `start` → `valid` never rises, `done` pulses 2 cycles after the start edge, `cnt`=0.
- **Full scan:** all 32 bytes preloaded as 8'h31 → 32 bytes emitted, last with `dir`=31, `cnt`=32, `dir` returns to 0 after DONE.
- **Backpressure:** string "2156"; hold `ready`=0 for 5 cycles on the second byte → `dataOut`=8'h31 and `valid`=1 stay stable throughout; no byte is lost or duplicated.
- **Start and reset:** pulse `start` again mid-scan → ignored, and the sequence is unchanged. Drop `rst_n` during SEND → outputs go to reset values asynchronously. A later `start` restarts from address 0.
